regfile_bank: RTL and testbench

32 × 32-bit register storage bank that feeds the combinational 32:1 read selector of the register file; each register's contents drive one selector data input continuously. Provides one byte-maskable synchronous write port, an optional hardwired-zero register 0, and a sequenced clear-all sweep with a busy flag. All state is held here; the downstream read path stays purely combinational.

---
 rtl/regfile_bank.sv | 148 ++++++++++++++
 tb/tb_regfile_bank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bank.sv
// 32x32 register storage bank with a byte-masked write port, optional hardwired-zero reg 0 and a clear sweep.
// Latency: writes land 1 edge after sampling; the sweep clears one register per cycle over 32 cycles.
// Backpressure: none; writes and clear requests that arrive while oBusy is high are dropped.
module regfile_bank #(
    parameter bit          ZERO_REG  = 1'b1,
    parameter logic [31:0] CLR_VALUE = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iWe,
    input  logic [4:0]  iWaddr,
    input  logic [31:0] iWdata,
    input  logic [3:0]  iByteEn,
    input  logic        iClr,
    output logic        oBusy,
    output logic [31:0] oQ0,
    output logic [31:0] oQ1,
    output logic [31:0] oQ2,
    output logic [31:0] oQ3,
    output logic [31:0] oQ4,
    output logic [31:0] oQ5,
    output logic [31:0] oQ6,
    output logic [31:0] oQ7,
    output logic [31:0] oQ8,
    output logic [31:0] oQ9,
    output logic [31:0] oQ10,
    output logic [31:0] oQ11,
    output logic [31:0] oQ12,
    output logic [31:0] oQ13,
    output logic [31:0] oQ14,
    output logic [31:0] oQ15,
    output logic [31:0] oQ16,
    output logic [31:0] oQ17,
    output logic [31:0] oQ18,
    output logic [31:0] oQ19,
    output logic [31:0] oQ20,
    output logic [31:0] oQ21,
    output logic [31:0] oQ22,
    output logic [31:0] oQ23,
    output logic [31:0] oQ24,
    output logic [31:0] oQ25,
    output logic [31:0] oQ26,
    output logic [31:0] oQ27,
    output logic [31:0] oQ28,
    output logic [31:0] oQ29,
    output logic [31:0] oQ30,
    output logic [31:0] oQ31
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [4:0]  sweepCnt;
    logic [31:0] regs [32];
    logic        wrEn;
    logic        sweepSkip;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iClr) stateNext = CLEAR;
            CLEAR:   if (sweepCnt == 5'd31) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        oBusy = (state == CLEAR);
    end

    // Counter only runs during the sweep and naturally wraps to 0 as the sweep ends.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sweepCnt <= '0;
        end else if (state == CLEAR) begin
            sweepCnt <= sweepCnt + 5'd1;
        end else begin
            sweepCnt <= '0;
        end
    end

    assign wrEn      = (state == IDLE) && iWe && !(ZERO_REG && (iWaddr == 5'd0));
    assign sweepSkip = ZERO_REG && (sweepCnt == 5'd0);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            if (!sweepSkip) begin
                regs[sweepCnt] <= CLR_VALUE;
            end
        end else if (wrEn) begin
            for (int k = 0; k < 4; k++) begin
                if (iByteEn[k]) begin
                    regs[iWaddr][8*k +: 8] <= iWdata[8*k +: 8];
                end
            end
        end
    end

    assign oQ0  = ZERO_REG ? 32'h0 : regs[0];
    assign oQ1  = regs[1];
    assign oQ2  = regs[2];
    assign oQ3  = regs[3];
    assign oQ4  = regs[4];
    assign oQ5  = regs[5];
    assign oQ6  = regs[6];
    assign oQ7  = regs[7];
    assign oQ8  = regs[8];
    assign oQ9  = regs[9];
    assign oQ10 = regs[10];
    assign oQ11 = regs[11];
    assign oQ12 = regs[12];
    assign oQ13 = regs[13];
    assign oQ14 = regs[14];
    assign oQ15 = regs[15];
    assign oQ16 = regs[16];
    assign oQ17 = regs[17];
    assign oQ18 = regs[18];
    assign oQ19 = regs[19];
    assign oQ20 = regs[20];
    assign oQ21 = regs[21];
    assign oQ22 = regs[22];
    assign oQ23 = regs[23];
    assign oQ24 = regs[24];
    assign oQ25 = regs[25];
    assign oQ26 = regs[26];
    assign oQ27 = regs[27];
    assign oQ28 = regs[28];
    assign oQ29 = regs[29];
    assign oQ30 = regs[30];
    assign oQ31 = regs[31];

endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: two instances (reg 0 hardwired / ordinary) share stimulus and are
// checked every cycle against a reference model through an expectation queue.
module tb_regfile_bank;

    localparam logic [31:0] CLR = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rstN;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  byteEn;
    logic        clr;
    wire         busy;
    wire         busyNz;
    wire  [31:0] q   [32];
    wire  [31:0] qNz [32];

    always #5 clk = ~clk;

    regfile_bank #(.ZERO_REG(1'b1), .CLR_VALUE(CLR)) dut (
        .iClk(clk), .iRst_n(rstN), .iWe(we), .iWaddr(waddr), .iWdata(wdata),
        .iByteEn(byteEn), .iClr(clr), .oBusy(busy),
        .oQ0(q[0]),   .oQ1(q[1]),   .oQ2(q[2]),   .oQ3(q[3]),
        .oQ4(q[4]),   .oQ5(q[5]),   .oQ6(q[6]),   .oQ7(q[7]),
        .oQ8(q[8]),   .oQ9(q[9]),   .oQ10(q[10]), .oQ11(q[11]),
        .oQ12(q[12]), .oQ13(q[13]), .oQ14(q[14]), .oQ15(q[15]),
        .oQ16(q[16]), .oQ17(q[17]), .oQ18(q[18]), .oQ19(q[19]),
        .oQ20(q[20]), .oQ21(q[21]), .oQ22(q[22]), .oQ23(q[23]),
        .oQ24(q[24]), .oQ25(q[25]), .oQ26(q[26]), .oQ27(q[27]),
        .oQ28(q[28]), .oQ29(q[29]), .oQ30(q[30]), .oQ31(q[31])
    );

    regfile_bank #(.ZERO_REG(1'b0), .CLR_VALUE(CLR)) dutNz (
        .iClk(clk), .iRst_n(rstN), .iWe(we), .iWaddr(waddr), .iWdata(wdata),
        .iByteEn(byteEn), .iClr(clr), .oBusy(busyNz),
        .oQ0(qNz[0]),   .oQ1(qNz[1]),   .oQ2(qNz[2]),   .oQ3(qNz[3]),
        .oQ4(qNz[4]),   .oQ5(qNz[5]),   .oQ6(qNz[6]),   .oQ7(qNz[7]),
        .oQ8(qNz[8]),   .oQ9(qNz[9]),   .oQ10(qNz[10]), .oQ11(qNz[11]),
        .oQ12(qNz[12]), .oQ13(qNz[13]), .oQ14(qNz[14]), .oQ15(qNz[15]),
        .oQ16(qNz[16]), .oQ17(qNz[17]), .oQ18(qNz[18]), .oQ19(qNz[19]),
        .oQ20(qNz[20]), .oQ21(qNz[21]), .oQ22(qNz[22]), .oQ23(qNz[23]),
        .oQ24(qNz[24]), .oQ25(qNz[25]), .oQ26(qNz[26]), .oQ27(qNz[27]),
        .oQ28(qNz[28]), .oQ29(qNz[29]), .oQ30(qNz[30]), .oQ31(qNz[31])
    );

    // Reference model state
    logic [31:0] m   [32];
    logic [31:0] mNz [32];
    bit          mBusy;
    int          mCnt;

    // sel 0..31 -> q, 32..63 -> qNz, 64 -> busy, 65 -> busyNz
    typedef struct {
        int          sel;
        logic [31:0] exp;
    } sbEntry_t;
    sbEntry_t sbQ [$];

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        if (sel < 32)       return q[sel];
        else if (sel < 64)  return qNz[sel-32];
        else if (sel == 64) return {31'b0, busy};
        else                return {31'b0, busyNz};
    endfunction

    function automatic string selName(input int sel);
        if (sel < 32)       return $sformatf("zr.q%0d", sel);
        else if (sel < 64)  return $sformatf("nz.q%0d", sel-32);
        else if (sel == 64) return "zr.busy";
        else                return "nz.busy";
    endfunction

    task automatic expectAll();
        for (int i = 0; i < 32; i++) begin
            sbQ.push_back('{sel: i,      exp: m[i]});
            sbQ.push_back('{sel: i + 32, exp: mNz[i]});
        end
        sbQ.push_back('{sel: 64, exp: {31'b0, mBusy}});
        sbQ.push_back('{sel: 65, exp: {31'b0, mBusy}});
    endtask

    task automatic drainSb();
        sbEntry_t e;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkVal(selName(e.sel), observe(e.sel), e.exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            m[i]   = '0;
            mNz[i] = '0;
        end
        mBusy = 1'b0;
        mCnt  = 0;
    endtask

    // Behaviour of one rising edge given the inputs sampled at it
    task automatic modelEdge(input bit w, input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] be, input bit c);
        if (mBusy) begin
            if (mCnt != 0) m[mCnt] = CLR;
            mNz[mCnt] = CLR;
            if (mCnt == 31) begin
                mBusy = 1'b0;
                mCnt  = 0;
            end else begin
                mCnt++;
            end
        end else begin
            if (w) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) begin
                        if (a != 5'd0) m[a][8*k +: 8] = d[8*k +: 8];
                        mNz[a][8*k +: 8] = d[8*k +: 8];
                    end
                end
            end
            if (c) begin
                mBusy = 1'b1;
                mCnt  = 0;
            end
        end
    endtask

    task automatic step(input bit w, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit c);
        we = w; waddr = a; wdata = d; byteEn = be; clr = c;
        modelEdge(w, a, d, be, c);
        expectAll();
        @(posedge clk);
        #1;
        drainSb();
        we = 1'b0; clr = 1'b0; byteEn = 4'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; we = 1'b0; waddr = '0; wdata = '0; byteEn = '0; clr = 1'b0;
        modelReset();
        @(posedge clk); @(posedge clk); #1;
        expectAll(); drainSb();
        rstN = 1'b1;
        idle(1);

        // Asynchronous reset between edges
        step(1'b1, 5'd9, 32'h0000_0055, 4'hF, 1'b0);
        checkVal("pre_async_q9", q[9], 32'h0000_0055);
        #3 rstN = 1'b0;
        modelReset();
        #1;
        expectAll(); drainSb();
        @(posedge clk); #1;
        rstN = 1'b1;

        // Full-word then masked write
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF, 1'b0);
        checkVal("full_write_q5", q[5], 32'hDEAD_BEEF);
        step(1'b1, 5'd5, 32'h1122_3344, 4'b0101, 1'b0);
        checkVal("byte_merge_q5", q[5], 32'hDE22_BE44);
        step(1'b1, 5'd5, 32'h0000_0000, 4'b0000, 1'b0);
        checkVal("be_zero_q5", q[5], 32'hDE22_BE44);

        // Register 0 behaviour in both builds
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 1'b0);
        checkVal("zero_reg_q0", q[0], 32'h0);
        checkVal("plain_reg_q0", qNz[0], 32'hFFFF_FFFF);

        // Fill with index + 0x100, then sweep with a dropped write and a re-pulsed clear
        for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 32'h100 + i, 4'hF, 1'b0);
        step(1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
        checkVal("busy_rise", {31'b0, busy}, 32'd1);
        for (int e = 1; e <= 32; e++) begin
            if (e == 10)      step(1'b1, 5'd3, 32'h3333_3333, 4'hF, 1'b0);
            else if (e == 20) step(1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
            else              step(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
            if (e == 7)  checkVal("q7_before_edge8", q[7], 32'h0000_0107);
            if (e == 8)  checkVal("q7_at_edge8", q[7], CLR);
            if (e == 31) checkVal("busy_edge31", {31'b0, busy}, 32'd1);
        end
        checkVal("busy_fall_edge32", {31'b0, busy}, 32'd0);
        checkVal("dropped_write_q3", q[3], CLR);
        checkVal("q31_cleared", q[31], CLR);

        // Write and clear at the same edge
        step(1'b1, 5'd2, 32'h0000_1234, 4'hF, 1'b1);
        checkVal("simul_q2_edge0", q[2], 32'h0000_1234);
        step(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
        step(1'b0, 5'd0, 32'h0, 4'h0, 1'b0);
        checkVal("simul_q2_edge3", q[2], CLR);
        idle(29);
        checkVal("simul_busy_done", {31'b0, busy}, 32'd0);
        step(1'b1, 5'd6, 32'h0BAD_F00D, 4'hF, 1'b0);
        checkVal("first_write_after_sweep", q[6], 32'h0BAD_F00D);

        // Reset in the middle of a sweep
        step(1'b1, 5'd20, 32'h2020_2020, 4'hF, 1'b0);
        step(1'b0, 5'd0, 32'h0, 4'h0, 1'b1);
        idle(12);
        #2 rstN = 1'b0;
        modelReset();
        #1;
        expectAll(); drainSb();
        @(posedge clk); #1;
        rstN = 1'b1;
        step(1'b1, 5'd4, 32'hCAFE_F00D, 4'hF, 1'b0);
        checkVal("write_after_reset", q[4], 32'hCAFE_F00D);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
